// File: rtl/multiword_add_sequencer.sv
// Multi-cycle W-bit add/subtract built from one N-bit adder slice.
// Each RUN cycle handles one slice, least-significant slice first.
module multiword_add_sequencer #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int K  = W / N;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [W-1:0]  ra, rb;
  logic          carry;
  logic [IW-1:0] idx;

  logic [N-1:0]  sa, sb, ss;
  logic          sc, msb_cin, last;
  int            off;

  // The single shared slice adder
  always_comb begin
    off     = int'(idx) * N;
    sa      = ra[off +: N];
    sb      = rb[off +: N];
    {sc, ss} = {1'b0, sa} + {1'b0, sb} + {{N{1'b0}}, carry};
    msb_cin = sa[N-1] ^ sb[N-1] ^ ss[N-1];
    last    = (idx == IW'(K - 1));
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid)  state_n = RUN;
      RUN:  if (last)      state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra       <= '0;
      rb       <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        ra    <= a;
        // Subtract as a + ~b + 1; the +1 enters as slice-0 carry
        rb    <= b ^ {W{sub}};
        carry <= sub;
        idx   <= '0;
      end
      if (state == RUN) begin
        sum[off +: N] <= ss;
        carry         <= sc;
        idx           <= last ? '0 : idx + IW'(1);
        if (last) begin
          cout     <= sc;
          overflow <= sc ^ msb_cin;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (W=32, N=8).
// Driver pushes expected results; a negedge monitor pops on handshake.
module tb_multiword_add_sequencer;

  localparam int W   = 32;
  localparam int N   = 8;
  localparam int K   = W / N;
  localparam int LIM = 100;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   prev_acc = 0;
  bit   prev_ov = 0;
  exp_t q[$];

  multiword_add_sequencer #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: latency on out_valid rise, result compare on handshake
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_ov)
      chk("latency", W'(cyc - acc_cyc), W'(K));
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", W'(cout), W'(e.c));
        chk("overflow", W'(overflow), W'(e.o));
      end
    end
    prev_ov <= out_valid;
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic ts, input logic [W-1:0] es,
                       input logic ec, input logic eo,
                       input bit push, input bit keep);
    int n;
    exp_t e;
    a = ta;
    b = tb_;
    sub = ts;
    in_valid = 1;
    n = 0;
    while (!in_ready && n < LIM) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == LIM) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=busy required=ready");
    end
    e.s = es;
    e.c = ec;
    e.o = eo;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    prev_acc = acc_cyc;
    acc_cyc = cyc;
    if (!keep) in_valid = 0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n == LIM) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout actual=0 required=1");
    end
  endtask

  initial begin
    int n;
    rst = 1;
    in_valid = 0;
    a = 0;
    b = 0;
    sub = 0;
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", W'({cout, overflow}), 0);

    // Basic add, full ripple, signed overflow cases
    issue(32'h0000_00FF, 32'h1, 0, 32'h0000_0100, 0, 0, 1, 0);
    issue(32'hFFFF_FFFF, 32'h1, 0, 32'h0000_0000, 1, 0, 1, 0);
    issue(32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 0, 1, 1, 0);
    issue(32'h8000_0000, 32'h1, 1, 32'h7FFF_FFFF, 1, 1, 1, 0);

    // Back-pressure with mid-RUN operand changes
    n = 0;
    while (!in_ready && n < LIM) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 0;
    issue(32'd5, 32'd7, 1, 32'hFFFF_FFFE, 0, 0, 1, 0);
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    sub = 0;
    in_valid = 1;
    wait_valid();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_sum", sum, 32'hFFFF_FFFE);
      chk("hold_cout", W'(cout), 0);
      chk("hold_in_ready", W'(in_ready), 0);
      chk("hold_valid", W'(out_valid), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    @(negedge clk);

    // Reset on the RUN edge with idx=2 discards the operation
    issue(32'h0102_0304, 32'h1111_1111, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", W'(in_ready), 1);
    chk("mid_rst_valid", W'(out_valid), 0);
    chk("mid_rst_sum", sum, 0);

    // Reset wins over an accept in the same cycle
    in_valid = 1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    in_valid = 0;
    @(negedge clk);
    chk("rst_vs_accept", W'(in_ready), 1);

    issue(32'd1, 32'd2, 0, 32'd3, 0, 0, 1, 0);

    // Back-to-back with in_valid and out_ready held high
    issue(32'h1234_5678, 32'h1111_1111, 0, 32'h2345_6789, 0, 0, 1, 1);
    issue(32'hFFFF_0000, 32'h0001_0000, 0, 32'h0000_0000, 1, 0, 1, 1);
    chk("b2b_space1", W'(acc_cyc - prev_acc), W'(K + 2));
    issue(32'd10, 32'd3, 1, 32'd7, 1, 0, 1, 1);
    chk("b2b_space2", W'(acc_cyc - prev_acc), W'(K + 2));
    issue(32'h8000_0000, 32'h8000_0000, 0, 32'h0, 1, 1, 1, 0);
    chk("b2b_space3", W'(acc_cyc - prev_acc), W'(K + 2));

    n = 0;
    while (q.size() != 0 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", W'(q.size()), 0);
    @(negedge clk);
    chk("idle_retain_sum", sum, 32'h0);
    chk("idle_retain_ovf", W'(overflow), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter N, default 8, meaning adder slice width; W SHALL be an integer multiple of N; K = W/N.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-007 The block SHALL have port a, input, W bits: operand A.
REQ-008 The block SHALL have port b, input, W bits: operand B.
REQ-009 The block SHALL have port sub, input, 1 bit: 1 = compute a-b, 0 = compute a+b.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-012 The block SHALL have port sum, output, W bits: result, modulo 2^W.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of bit W-1 (for sub: 1 = no borrow).
REQ-014 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow of the operation.

Function
REQ-015 The block SHALL contain exactly one N-bit combinational adder slice (a, b, cin -> s, cout); all arithmetic SHALL go through it, one slice per cycle.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; reset state is IDLE.
REQ-017 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-018 Accept edge (IDLE, in_valid=1): register a, b XOR {W{sub}}, and sub; set carry register = sub, slice index = 0; go to RUN.
REQ-019 Each RUN edge: slice operands = bits [idx*N +: N] of registered A and B; adder cin = carry register; write s into sum[idx*N +: N]; carry register <= adder cout; idx <= idx+1.
REQ-020 The RUN edge with idx = K-1 SHALL go to DONE and SHALL latch cout = adder cout and overflow = adder cout XOR carry into bit W-1.
REQ-021 Latency: out_valid SHALL rise exactly K edges after the accept edge; throughput is one operation per K+2 cycles at best.
REQ-022 In DONE, sum/cout/overflow SHALL hold stable while out_valid=1 and out_ready=0; the edge with out_ready=1 SHALL return to IDLE.
REQ-023 Inputs a, b, sub, in_valid SHALL be ignored outside IDLE; changing them during RUN SHALL NOT affect the result.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 The index counter SHALL be ceil(log2(K)) bits (min 1) and SHALL NOT wrap within an operation; K=1 SHALL give one RUN edge.
REQ-026 sum, cout and overflow SHALL retain the last result in IDLE until the next accept edge; partially written sum is not visible as valid.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, in_ready=1 after that edge, out_valid=0, sum=0, cout=0, overflow=0, carry=0, idx=0.
REQ-028 rst SHALL take priority over every other event, including an accept edge or a result handshake in the same cycle; an operation in flight is discarded with no output.

Verification (W=32, N=8)
REQ-029 a=0x0000_00FF, b=0x0000_0001, sub=0 -> out_valid 4 edges after accept; sum=0x0000_0100, cout=0, overflow=0.
REQ-030 a=0xFFFF_FFFF, b=0x0000_0001, sub=0 -> sum=0x0000_0000, cout=1, overflow=0 (full carry ripple through all slices).
REQ-031 a=0x7FFF_FFFF, b=0x0000_0001, sub=0 -> sum=0x8000_0000, overflow=1; a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, overflow=1, cout=1.
REQ-032 a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0; hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0; change a/b mid-RUN -> no effect.
REQ-033 rst asserted on RUN edge idx=2 -> next cycle IDLE, out_valid=0, sum=0; next request a=1, b=2 -> sum=3.
REQ-034 Back-to-back requests with in_valid held 1 and out_ready held 1 -> each result correct, accept edges spaced exactly K+2 cycles apart.
